// File: rtl/age_sort_pipe_pkg.sv
// Shared definitions for the age sort pipeline: record layout helpers and the bitonic schedule.
// Record layout, LSB first: mc, eject, ppv, port index, time, valid.
package age_sort_pipe_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned num_stages(input int unsigned n);
    int unsigned l;
    l = idx_w(n);
    return l * (l + 1) / 2;
  endfunction

  function automatic int unsigned rec_w(input int unsigned tw, input int unsigned iw,
                                        input int unsigned pw);
    return 1 + tw + iw + pw + 2;
  endfunction

  // Stage s of the bitonic network: merge block size k, compare distance j.
  function automatic int unsigned stage_k(input int unsigned n, input int unsigned s);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = n;
    for (int unsigned k = 2; k <= n; k = k * 2) begin
      for (int unsigned j = k / 2; j >= 1; j = j / 2) begin
        if (cnt == s) res = k;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic int unsigned stage_j(input int unsigned n, input int unsigned s);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 1;
    for (int unsigned k = 2; k <= n; k = k * 2) begin
      for (int unsigned j = k / 2; j >= 1; j = j / 2) begin
        if (cnt == s) res = j;
        cnt++;
      end
    end
    return res;
  endfunction

  // Higher priority lands on the lower index when the position's k bit is clear.
  function automatic bit cmp_desc(input int unsigned pos, input int unsigned k);
    return (pos & k) == 0;
  endfunction

endpackage

// File: rtl/age_cmp_swap.sv
// One bitonic compare-exchange element; purely combinational.
module age_cmp_swap
  import age_sort_pipe_pkg::*;
#(
  parameter int unsigned TimeWidth = 8,
  parameter int unsigned IdxWidth  = 2,
  parameter int unsigned PpvWidth  = 4,
  parameter bit          Desc      = 1'b1,
  localparam int unsigned RecWidth = rec_w(TimeWidth, IdxWidth, PpvWidth)
) (
  input  logic [RecWidth-1:0] a_i,
  input  logic [RecWidth-1:0] b_i,
  output logic [RecWidth-1:0] lo_o,
  output logic [RecWidth-1:0] hi_o
);

  localparam int unsigned KeyWidth = 1 + TimeWidth + IdxWidth;

  logic [KeyWidth-1:0] key_a, key_b;
  logic                swap;

  // Inverted index makes the whole priority a single unsigned magnitude compare.
  always_comb begin
    key_a = {a_i[RecWidth-1 -: 1 + TimeWidth], ~a_i[2 + PpvWidth +: IdxWidth]};
    key_b = {b_i[RecWidth-1 -: 1 + TimeWidth], ~b_i[2 + PpvWidth +: IdxWidth]};
    swap  = Desc ? (key_b > key_a) : (key_a > key_b);
    lo_o  = swap ? b_i : a_i;
    hi_o  = swap ? a_i : b_i;
  end

endmodule

// File: rtl/age_sort_pipe.sv
// Pipelined bitonic sorter ranking flit headers by validity, age and port index.
module age_sort_pipe
  import age_sort_pipe_pkg::*;
#(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned TIME_WIDTH = 8,
  parameter int unsigned PPV_WIDTH  = 4,
  parameter int unsigned REG_EVERY  = 1,
  localparam int unsigned IDX_W     = idx_w(NUM_IN)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            in_frame,
  input  logic [NUM_IN-1:0]               in_valid,
  input  logic [NUM_IN*TIME_WIDTH-1:0]    in_time,
  input  logic [NUM_IN*PPV_WIDTH-1:0]     in_ppv,
  input  logic [NUM_IN-1:0]               in_eject,
  input  logic [NUM_IN-1:0]               in_mc,
  output logic                            out_frame,
  output logic [NUM_IN-1:0]               rank_valid,
  output logic [NUM_IN*IDX_W-1:0]         rank_dir,
  output logic [NUM_IN*PPV_WIDTH-1:0]     rank_ppv,
  output logic [NUM_IN-1:0]               rank_eject,
  output logic [NUM_IN-1:0]               rank_mc
);

  localparam int unsigned RecW      = rec_w(TIME_WIDTH, IDX_W, PPV_WIDTH);
  localparam int unsigned NumStages = num_stages(NUM_IN);

  logic [NUM_IN*RecW-1:0] in_rec;
  logic [NUM_IN*RecW-1:0] stg [NumStages+1];
  logic                   frm [NumStages+1];

  // Bubbles enter as all-zero records so their rank outputs read as zero.
  always_comb begin
    in_rec = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_frame) begin
        in_rec[i*RecW +: RecW] = {in_valid[i], in_time[i*TIME_WIDTH +: TIME_WIDTH],
                                  IDX_W'(i), in_ppv[i*PPV_WIDTH +: PPV_WIDTH],
                                  in_eject[i], in_mc[i]};
      end
    end
  end

  assign stg[0] = in_rec;
  assign frm[0] = in_frame;

  for (genvar s = 0; s < NumStages; s++) begin : g_stage
    localparam int unsigned K = stage_k(NUM_IN, s);
    localparam int unsigned J = stage_j(NUM_IN, s);

    logic [NUM_IN*RecW-1:0] cx;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_pos
      if ((i & J) == 0) begin : g_cmp
        age_cmp_swap #(
          .TimeWidth (TIME_WIDTH),
          .IdxWidth  (IDX_W),
          .PpvWidth  (PPV_WIDTH),
          .Desc      (cmp_desc(i, K))
        ) u_cmp (
          .a_i  (stg[s][i*RecW +: RecW]),
          .b_i  (stg[s][(i+J)*RecW +: RecW]),
          .lo_o (cx[i*RecW +: RecW]),
          .hi_o (cx[(i+J)*RecW +: RecW])
        );
      end
    end

    if ((((s + 1) % REG_EVERY) == 0) || (s == NumStages - 1)) begin : g_reg
      logic [NUM_IN*RecW-1:0] stage_d, stage_q;
      logic                   frame_d, frame_q;

      always_comb begin
        stage_d = stage_q;
        frame_d = frame_q;
        if (en) begin
          stage_d = cx;
          frame_d = frm[s];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= '0;
          frame_q <= 1'b0;
        end else begin
          stage_q <= stage_d;
          frame_q <= frame_d;
        end
      end

      assign stg[s+1] = stage_q;
      assign frm[s+1] = frame_q;
    end else begin : g_thru
      assign stg[s+1] = cx;
      assign frm[s+1] = frm[s];
    end
  end

  logic [NUM_IN*TIME_WIDTH-1:0] unused_time;

  always_comb begin
    rank_valid  = '0;
    rank_dir    = '0;
    rank_ppv    = '0;
    rank_eject  = '0;
    rank_mc     = '0;
    unused_time = '0;
    for (int r = 0; r < NUM_IN; r++) begin
      rank_valid[r]                        = stg[NumStages][r*RecW + RecW - 1];
      unused_time[r*TIME_WIDTH +: TIME_WIDTH] =
          stg[NumStages][r*RecW + 2 + PPV_WIDTH + IDX_W +: TIME_WIDTH];
      rank_dir[r*IDX_W +: IDX_W]           = stg[NumStages][r*RecW + 2 + PPV_WIDTH +: IDX_W];
      rank_ppv[r*PPV_WIDTH +: PPV_WIDTH]   = stg[NumStages][r*RecW + 2 +: PPV_WIDTH];
      rank_eject[r]                        = stg[NumStages][r*RecW + 1];
      rank_mc[r]                           = stg[NumStages][r*RecW];
    end
  end

  assign out_frame = frm[NumStages];

endmodule
